// File: rtl/ysyx_22041405_sram_resp_pkg.sv
// rtl/ysyx_22041405_sram_resp_pkg.sv - shared constants and address decode for the sram responder
//
// Purpose: default address/data geometry and the byte-address -> {index, err}
// decode used by both the instruction and the data port.
// Contents:
//   ADDR_W        decode arithmetic width
//   WIDTH_DEFAULT default data/address width
//   STRB_W        byte-strobe width for the default data width
//   BASE_DEFAULT  byte address mapped to word 0
//   decode_t      {index, err} decode result
//   addr_decode() byte address -> decode_t
package ysyx_22041405_sram_resp_pkg;

  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned STRB_W        = WIDTH_DEFAULT / 8;
  localparam logic [ADDR_W-1:0] BASE_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [ADDR_W-3:0] index;
    logic              err;
  } decode_t;

  // Addresses below base wrap to a huge offset, so a single unsigned range
  // compare catches both "below base" and "past the end of storage".
  function automatic decode_t addr_decode(input logic [ADDR_W-1:0] addr,
                                          input logic [ADDR_W-1:0] base,
                                          input logic [ADDR_W-3:0] depth);
    logic [ADDR_W-1:0] offset;
    decode_t           res;
    offset    = addr - base;
    res.index = offset[ADDR_W-1:2];
    res.err   = (addr[1:0] != 2'b00) || (offset[ADDR_W-1:2] >= depth);
    return res;
  endfunction

endpackage

// File: rtl/ysyx_22041405_rd_pipe.sv
// rtl/ysyx_22041405_rd_pipe.sv - LAT-deep valid-tagged read response pipeline
//
// Purpose: delays a {valid, err, data} response by LAT registered stages.
// Data in a stage only advances when the stage feeding it is valid, so the
// output data holds its last delivered value while out_valid is low.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_err   response tag entering stage 0
//   in_data           response data entering stage 0
//   out_valid/out_err response tag leaving the last stage
//   out_data          response data leaving the last stage
module ysyx_22041405_rd_pipe #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_err,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_err,
  output logic [WIDTH-1:0] out_data
);

  logic [LAT-1:0]            valid_q, valid_d;
  logic [LAT-1:0]            err_q, err_d;
  logic [LAT-1:0][WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    err_d      = err_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    err_d[0]   = in_err;
    if (in_valid) data_d[0] = in_data;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      err_d[i]   = err_q[i-1];
      if (valid_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      err_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_err   = err_q[LAT-1];
  assign out_data  = data_q[LAT-1];

endmodule

// File: rtl/ysyx_22041405_sram_resp.sv
// rtl/ysyx_22041405_sram_resp.sv - shared-storage iram/dram memory responder
//
// Purpose: word-addressed storage serving a read-only instruction port and a
// read/write data port, with responses returned LAT cycles after the request.
// Ports:
//   clk, rst                               clock, asynchronous active-high reset
//   iram_re, iram_addr                     instruction read request
//   iram_rdata, iram_rvalid, iram_err      instruction response
//   dram_re, dram_we, dram_addr            data read/write request
//   dram_wdata, dram_wstrb                 write data and byte enables
//   dram_rdata, dram_rvalid, dram_err      data response
module ysyx_22041405_sram_resp
  import ysyx_22041405_sram_resp_pkg::*;
#(
  parameter int               WIDTH = WIDTH_DEFAULT,
  parameter int               DEPTH = 4096,
  parameter int               LAT   = 1,
  parameter logic [WIDTH-1:0] BASE  = WIDTH'(BASE_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iram_re,
  input  logic [WIDTH-1:0]   iram_addr,
  output logic [WIDTH-1:0]   iram_rdata,
  output logic               iram_rvalid,
  output logic               iram_err,
  input  logic               dram_re,
  input  logic               dram_we,
  input  logic [WIDTH-1:0]   dram_addr,
  input  logic [WIDTH-1:0]   dram_wdata,
  input  logic [WIDTH/8-1:0] dram_wstrb,
  output logic [WIDTH-1:0]   dram_rdata,
  output logic               dram_rvalid,
  output logic               dram_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  decode_t          i_dec, d_dec;
  logic [IDX_W-1:0] i_idx, d_idx;
  logic [WIDTH-1:0] i_rd, d_rd;
  logic             d_wr;
  logic             d_tag_err;

  // Storage is read combinationally and captured by stage 0 of each pipe on
  // the same edge that commits a write, which gives read-before-write for
  // any same-cycle read of the written word on either port.
  always_comb begin
    i_dec     = addr_decode(ADDR_W'(iram_addr), ADDR_W'(BASE), (ADDR_W-2)'(DEPTH));
    d_dec     = addr_decode(ADDR_W'(dram_addr), ADDR_W'(BASE), (ADDR_W-2)'(DEPTH));
    i_idx     = IDX_W'(i_dec.index);
    d_idx     = IDX_W'(d_dec.index);
    i_rd      = i_dec.err ? '0 : mem[i_idx];
    d_rd      = d_dec.err ? '0 : mem[d_idx];
    d_wr      = dram_we && !d_dec.err;
    // A bad write with no read still returns an err pulse, untagged by valid.
    d_tag_err = d_dec.err && (dram_re || dram_we);
  end

  // Storage is deliberately outside the reset domain: contents survive rst.
  always_ff @(posedge clk) begin
    if (d_wr) begin
      for (int k = 0; k < NB; k++) begin
        if (dram_wstrb[k]) mem[d_idx][8*k +: 8] <= dram_wdata[8*k +: 8];
      end
    end
  end

  ysyx_22041405_rd_pipe #(.WIDTH(WIDTH), .LAT(LAT)) u_iram_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iram_re),
    .in_err    (iram_re && i_dec.err),
    .in_data   (i_rd),
    .out_valid (iram_rvalid),
    .out_err   (iram_err),
    .out_data  (iram_rdata)
  );

  ysyx_22041405_rd_pipe #(.WIDTH(WIDTH), .LAT(LAT)) u_dram_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dram_re),
    .in_err    (d_tag_err),
    .in_data   (d_rd),
    .out_valid (dram_rvalid),
    .out_err   (dram_err),
    .out_data  (dram_rdata)
  );

endmodule

// File: tb/tb_ysyx_22041405_sram_resp.sv
// tb/tb_ysyx_22041405_sram_resp.sv - self-checking bench for the sram responder
module tb_ysyx_22041405_sram_resp;

  localparam int          WIDTH  = 32;
  localparam int          DEPTH  = 4096;
  localparam int          LAT    = 3;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          REGION = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        iram_re;
  logic [31:0] iram_addr;
  logic [31:0] iram_rdata;
  logic        iram_rvalid;
  logic        iram_err;
  logic        dram_re;
  logic        dram_we;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wstrb;
  logic [31:0] dram_rdata;
  logic        dram_rvalid;
  logic        dram_err;

  ysyx_22041405_sram_resp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LAT(LAT), .BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .iram_re(iram_re), .iram_addr(iram_addr), .iram_rdata(iram_rdata),
    .iram_rvalid(iram_rvalid), .iram_err(iram_err),
    .dram_re(dram_re), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wstrb(dram_wstrb), .dram_rdata(dram_rdata),
    .dram_rvalid(dram_rvalid), .dram_err(dram_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          e;
    logic [31:0] d;
  } resp_t;

  resp_t       sched_i [int];
  resp_t       sched_d [int];
  logic [31:0] mem_m [int];
  logic [31:0] last_i, last_d;
  logic        exp_iv, exp_ie, exp_dv, exp_de;
  logic [31:0] exp_id, exp_dd;
  int          cyc;
  int          checks;
  int          failures;

  function automatic bit addr_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 != 0) || (off >= 32'(DEPTH * 4));
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] waddr(input int w);
    return BASE + 32'(w) * 4;
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 19);
    if (sel == 0) return waddr($urandom_range(0, REGION - 1)) + 32'($urandom_range(1, 3));
    if (sel == 1) return BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255)) * 4;
    if (sel == 2) return BASE - 32'($urandom_range(1, 64)) * 4;
    return waddr($urandom_range(0, REGION - 1));
  endfunction

  task automatic idle();
    iram_re = 0; dram_re = 0; dram_we = 0; dram_wstrb = '0;
  endtask

  task automatic model_reset();
    sched_i.delete(); sched_d.delete();
    last_i = '0; last_d = '0;
    exp_iv = 0; exp_ie = 0; exp_id = '0;
    exp_dv = 0; exp_de = 0; exp_dd = '0;
  endtask

  // Advance one clock; the model samples the requests at the edge and
  // publishes what each port must show for the cycle that follows.
  task automatic step();
    resp_t       r;
    logic [31:0] w;
    int          k;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (iram_re) begin
        r.v = 1; r.e = addr_err(iram_addr);
        r.d = r.e ? 32'h0 : mem_m[word_of(iram_addr)];
        sched_i[cyc + LAT - 1] = r;
      end
      if (dram_re || (dram_we && addr_err(dram_addr))) begin
        r.v = dram_re; r.e = addr_err(dram_addr);
        r.d = (dram_re && !r.e) ? mem_m[word_of(dram_addr)] : 32'h0;
        sched_d[cyc + LAT - 1] = r;
      end
      if (dram_we && !addr_err(dram_addr)) begin
        k = word_of(dram_addr);
        w = mem_m.exists(k) ? mem_m[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (dram_wstrb[b]) w[8*b +: 8] = dram_wdata[8*b +: 8];
        mem_m[k] = w;
      end
    end
    if (sched_i.exists(cyc)) begin
      r = sched_i[cyc]; sched_i.delete(cyc);
      exp_iv = r.v; exp_ie = r.e;
      if (r.v) last_i = r.d;
    end else begin
      exp_iv = 0; exp_ie = 0;
    end
    if (sched_d.exists(cyc)) begin
      r = sched_d[cyc]; sched_d.delete(cyc);
      exp_dv = r.v; exp_de = r.e;
      if (r.v) last_d = r.d;
    end else begin
      exp_dv = 0; exp_de = 0;
    end
    exp_id = last_i;
    exp_dd = last_d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); iram_addr = BASE; dram_addr = BASE; dram_wdata = '0;
    model_reset();
    #2;
    checks++;
    if ({iram_rvalid, iram_err, iram_rdata, dram_rvalid, dram_err, dram_rdata} !== 66'h0) begin
      failures++;
      $display("FAIL reset_outputs got iv=%b ie=%b id=%h dv=%b de=%b dd=%h expected all zero",
               iram_rvalid, iram_err, iram_rdata, dram_rvalid, dram_err, dram_rdata);
    end
    step(); step();
    rst = 0;
    checks++;
    if ({iram_rvalid, dram_rvalid, iram_err, dram_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_hold got iv=%b dv=%b ie=%b de=%b expected 0", iram_rvalid, dram_rvalid, iram_err, dram_err);
    end
  endtask

  task automatic test_preload();
    for (int w = 0; w < REGION; w++) begin
      idle(); dram_we = 1; dram_addr = waddr(w); dram_wdata = $urandom; dram_wstrb = 4'hF;
      step();
      checks++;
      if ({dram_rvalid, dram_err, iram_rvalid} !== 3'b0) begin
        failures++;
        $display("FAIL preload_no_resp w=%0d got dv=%b de=%b iv=%b expected 0", w, dram_rvalid, dram_err, iram_rvalid);
      end
    end
    idle();
    repeat (LAT) step();
  endtask

  task automatic test_write_read();
    idle(); dram_we = 1; dram_addr = 32'h8000_0010; dram_wdata = 32'hDEAD_BEEF; dram_wstrb = 4'hF;
    step();
    idle(); dram_re = 1; dram_addr = 32'h8000_0010;
    step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL write_read got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", dram_rvalid, dram_err, dram_rdata);
    end
    step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      failures++;
      $display("FAIL rdata_hold got v=%b e=%b d=%h expected v=0 e=0 d=deadbeef", dram_rvalid, dram_err, dram_rdata);
    end
    idle(); dram_we = 1; dram_addr = 32'h8000_0014; dram_wdata = 32'h1122_3344; dram_wstrb = 4'hF;
    step();
    dram_wdata = 32'hAABB_CCDD; dram_wstrb = 4'b0101;
    step();
    idle(); dram_re = 1;
    step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b1, 1'b0, 32'h11BB_33DD}) begin
      failures++;
      $display("FAIL byte_strobe got v=%b e=%b d=%h expected v=1 e=0 d=11bb33dd", dram_rvalid, dram_err, dram_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit          ev;
    logic [31:0] ed;
    int          seen;
    seen = 0;
    for (int j = 0; j < LAT + 5; j++) begin
      idle();
      if (j < 4) begin iram_re = 1; iram_addr = waddr(j); end
      step();
      ev = (j >= LAT - 1) && (j < LAT + 3);
      ed = ev ? mem_m[j - (LAT - 1)] : exp_id;
      if (iram_rvalid === 1'b1) seen++;
      checks++;
      if ({iram_rvalid, iram_err} !== {ev, 1'b0} || (ev && iram_rdata !== ed)) begin
        failures++;
        $display("FAIL burst j=%0d got v=%b e=%b d=%h expected v=%b e=0 d=%h", j, iram_rvalid, iram_err, iram_rdata, ev, ed);
      end
    end
    checks++;
    if (seen != 4) begin
      failures++;
      $display("FAIL burst_count got %0d pulses expected 4", seen);
    end
  endtask

  task automatic test_raw();
    idle(); dram_we = 1; dram_addr = 32'h8000_0020; dram_wdata = 32'h0; dram_wstrb = 4'hF;
    step();
    dram_re = 1; dram_wdata = 32'h5; iram_re = 1; iram_addr = 32'h8000_0020;
    step();
    idle(); dram_re = 1;
    step();
    idle();
    repeat (LAT - 2) step();
    checks++;
    if ({dram_rvalid, dram_rdata, iram_rvalid, iram_rdata} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL read_before_write got dv=%b dd=%h iv=%b id=%h expected dv=1 dd=0 iv=1 id=0",
               dram_rvalid, dram_rdata, iram_rvalid, iram_rdata);
    end
    step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b1, 1'b0, 32'h5}) begin
      failures++;
      $display("FAIL write_visible got v=%b e=%b d=%h expected v=1 e=0 d=5", dram_rvalid, dram_err, dram_rdata);
    end
  endtask

  task automatic test_errors();
    idle(); dram_re = 1; dram_addr = 32'h8000_0002; iram_re = 1; iram_addr = 32'h7FFF_FFFC;
    step();
    idle(); dram_we = 1; dram_addr = 32'h8000_4000; dram_wdata = ~mem_m[0]; dram_wstrb = 4'hF;
    step();
    idle(); dram_re = 1; dram_addr = BASE;
    step();
    idle();
    repeat (LAT - 3) step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL misaligned_read got v=%b e=%b d=%h expected v=1 e=1 d=0", dram_rvalid, dram_err, dram_rdata);
    end
    checks++;
    if ({iram_rvalid, iram_err, iram_rdata} !== {1'b1, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL below_base_read got v=%b e=%b d=%h expected v=1 e=1 d=0", iram_rvalid, iram_err, iram_rdata);
    end
    step();
    checks++;
    if ({dram_rvalid, dram_err, iram_rvalid, iram_err} !== 4'b0100) begin
      failures++;
      $display("FAIL write_err_pulse got dv=%b de=%b iv=%b ie=%b expected dv=0 de=1 iv=0 ie=0",
               dram_rvalid, dram_err, iram_rvalid, iram_err);
    end
    step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b1, 1'b0, mem_m[0]}) begin
      failures++;
      $display("FAIL err_write_dropped got v=%b e=%b d=%h expected v=1 e=0 d=%h", dram_rvalid, dram_err, dram_rdata, mem_m[0]);
    end
  endtask

  task automatic test_reset_midop();
    idle(); dram_re = 1; dram_addr = waddr(1); iram_re = 1; iram_addr = waddr(2);
    step();
    idle();
    rst = 1;
    model_reset();
    #1;
    checks++;
    if ({iram_rvalid, iram_err, iram_rdata, dram_rvalid, dram_err, dram_rdata} !== 66'h0) begin
      failures++;
      $display("FAIL midop_reset_clear got iv=%b id=%h dv=%b dd=%h expected all zero", iram_rvalid, iram_rdata, dram_rvalid, dram_rdata);
    end
    step();
    rst = 0;
    for (int j = 0; j < LAT + 2; j++) begin
      step();
      checks++;
      if ({iram_rvalid, dram_rvalid, iram_err, dram_err} !== 4'b0) begin
        failures++;
        $display("FAIL stale_response j=%0d got iv=%b dv=%b ie=%b de=%b expected 0", j, iram_rvalid, dram_rvalid, iram_err, dram_err);
      end
    end
    dram_re = 1; dram_addr = waddr(1);
    step();
    idle();
    repeat (LAT - 1) step();
    checks++;
    if ({dram_rvalid, dram_err, dram_rdata} !== {1'b1, 1'b0, mem_m[1]}) begin
      failures++;
      $display("FAIL read_after_reset got v=%b e=%b d=%h expected v=1 e=0 d=%h", dram_rvalid, dram_err, dram_rdata, mem_m[1]);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400 + LAT; n++) begin
      idle();
      if (n < 400) begin
        iram_re = 1'($urandom); iram_addr = rand_addr();
        dram_re = 1'($urandom); dram_we = 1'($urandom); dram_addr = rand_addr();
        dram_wdata = $urandom; dram_wstrb = 4'($urandom);
      end
      step();
      checks++;
      if ({iram_rvalid, iram_err, iram_rdata} !== {exp_iv, exp_ie, exp_id}) begin
        failures++;
        $display("FAIL random_iram n=%0d got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 n, iram_rvalid, iram_err, iram_rdata, exp_iv, exp_ie, exp_id);
      end
      checks++;
      if ({dram_rvalid, dram_err, dram_rdata} !== {exp_dv, exp_de, exp_dd}) begin
        failures++;
        $display("FAIL random_dram n=%0d got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                 n, dram_rvalid, dram_err, dram_rdata, exp_dv, exp_de, exp_dd);
      end
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    test_reset();
    test_preload();
    test_write_read();
    test_back_to_back();
    test_raw();
    test_errors();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_22041405_sram_resp.md
Name: ysyx_22041405_sram_resp

Overview:
- Memory responder at the far end of the core's iram/dram initiator interfaces.
- Serves a read-only instruction port and a read/write data port from one shared word-addressed storage array.
- Read data returns through a LAT-deep valid-tagged pipeline; one request per port per cycle (fully pipelined).
- Used as the simulation/FPGA memory behind the core; also the reference responder for core-level benches.

Parameters:
- WIDTH, 32, data/address width.
- DEPTH, 4096, storage depth in words (power of two).
- LAT, 1, read latency in cycles, legal 1..4.
- BASE, 32'h8000_0000, byte address mapped to word 0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- iram_re  in  1  instruction read request.
- iram_addr  in  WIDTH  instruction byte address.
- iram_rdata  out  WIDTH  instruction read data.
- iram_rvalid  out  1  iram_rdata valid this cycle.
- iram_err  out  1  error response, qualified by iram_rvalid.
- dram_re  in  1  data read request.
- dram_we  in  1  data write request.
- dram_addr  in  WIDTH  data byte address.
- dram_wdata  in  WIDTH  write data.
- dram_wstrb  in  WIDTH/8  byte write enables.
- dram_rdata  out  WIDTH  data read data.
- dram_rvalid  out  1  dram_rdata valid this cycle.
- dram_err  out  1  error response, qualified by dram_rvalid.

Behaviour:
- Reset:
  - Asynchronous, active-high, single clock clk.
  - All outputs 0 at reset: rdata, rvalid, err.
  - All pipeline stages cleared, including valid bits.
  - Storage contents are not reset.
- Address decode:
  - offset = addr - BASE; index = offset[log2(DEPTH)+1:2].
  - Error when addr[1:0] != 0, or offset >= DEPTH*4 (this includes addr < BASE via unsigned wrap).
- Read (either port):
  - Request sampled at posedge with re = 1.
  - Response appears exactly LAT cycles later with rvalid = 1 for one cycle.
  - On error: rdata = 0 and err = 1.
  - Back-to-back requests produce back-to-back responses in request order.
  - rdata holds its last value when rvalid = 0; err = 0 when rvalid = 0.
- Write (dram only):
  - At posedge with dram_we = 1 and no error, byte lane k is written from dram_wdata when dram_wstrb[k] = 1.
  - An erroring write is dropped with no storage change.
  - A write produces no rvalid.
  - If dram_re = 0, an erroring write is reported with a one-cycle dram_err pulse LAT cycles later while dram_rvalid stays 0. This is the only case where err is asserted without rvalid.
- Simultaneous events:
  - dram_re and dram_we at the same address in the same cycle: read returns pre-write data (read-before-write); the write still lands.
  - iram read of the address dram is writing in the same cycle: iram returns old data.
  - The write is visible to any read sampled on a later edge.
  - dram_we with dram_wstrb = 0: no change and no error.
- Reset mid-operation:
  - In-flight responses are discarded and never emitted after rst deasserts.
  - Writes already committed persist.
- LAT = 1: a single registered output stage. LAT > 1 adds LAT-1 further registered stages of {valid, err, data}.
- No backpressure: the responder is always ready.

Decomposition:
- Shared package holds:
  - address-decode helper: byte address -> {index, err}.
  - BASE default.
  - WIDTH/8 strobe-width constant.
- One natural sub-module, ysyx_22041405_rd_pipe: a LAT-deep {valid, err, data} shift pipeline with async reset, instantiated once per port.
- Storage array and write logic stay in the top.

Test Plan:
- LAT = 1, write 32'hDEAD_BEEF to 0x8000_0010 with wstrb = 4'hF, then dram_re at 0x8000_0010 → next cycle dram_rvalid = 1, dram_rdata = 32'hDEAD_BEEF, dram_err = 0.
- Byte strobe: preload 32'h1122_3344, write 32'hAABB_CCDD with wstrb = 4'b0101 → readback 32'h11BB_33DD.
- LAT = 3, iram_re on 4 consecutive cycles at 0x8000_0000..0x8000_000C → rvalid high exactly on cycles 3..6 with data in order; no extra pulses.
- Same-cycle dram_re + dram_we at 0x8000_0020 (old 0, new 5) → response 0; following read returns 5. Concurrent iram_re there → 0.
- Errors: read 0x8000_0002 → rvalid = 1, err = 1, rdata = 0. Read 0x7FFF_FFFC → err = 1. Write to 0x8000_4000 with DEPTH = 4096 → storage unchanged and a one-cycle dram_err pulse with rvalid = 0.
- LAT = 2, issue a read, then assert rst for 1 cycle before its response → no rvalid ever appears; a fresh read after reset returns correct data.
